// File: rtl/hr_interval_calc_if.sv
// -----------------------------------------------------------------------------
// hr_interval_calc_if
// Beat-in / heart-rate-out bundle of the heart-rate computation stage.
//   i_beat_pulse    : one-cycle pulse per detected heartbeat (peak detector -> stage)
//   o_heart_rate    : averaged BPM, 0 = no lock
//   o_hr_valid      : level, high while the heart rate is locked
//   o_result_valid  : one-cycle pulse when o_heart_rate updates
//   o_timeout       : one-cycle pulse when lock is lost
// Modports: master = beat source / result consumer, slave = hr_interval_calc.
// -----------------------------------------------------------------------------
interface hr_interval_calc_if;
    logic       i_beat_pulse;
    logic [7:0] o_heart_rate;
    logic       o_hr_valid;
    logic       o_result_valid;
    logic       o_timeout;

    modport master (
        output i_beat_pulse,
        input  o_heart_rate, o_hr_valid, o_result_valid, o_timeout
    );

    modport slave (
        input  i_beat_pulse,
        output o_heart_rate, o_hr_valid, o_result_valid, o_timeout
    );
endinterface

// File: rtl/hr_interval_calc.sv
// -----------------------------------------------------------------------------
// hr_interval_calc
// Measures the beat-to-beat interval in ms, converts it to BPM with a 16-step
// restoring divider (60000 / interval) and smooths the result with a
// 2^P_AVG_LOG2-deep moving average.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : hr_interval_calc_if.slave (beat pulse in, heart rate / status out)
//
// Optional build macro:
//   HR_OUTLIER_REJECT_EN : reject quotients deviating from the current average
//                          by more than average/4; the third consecutive
//                          reject is accepted and reseeds the history.
//
// Latency: a beat presented in cycle T raises o_result_valid in cycle T+19
// (capture, 16 divide steps, average, output).
// -----------------------------------------------------------------------------
module hr_interval_calc #(
    parameter int P_SYS_CLK         = 50_000_000,
    parameter int P_MIN_INTERVAL_MS = 273,
    parameter int P_MAX_INTERVAL_MS = 2000,
    parameter int P_TIMEOUT_MS      = 3000,
    parameter int P_AVG_LOG2        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    hr_interval_calc_if.slave bus
);

    localparam int PRE   = P_SYS_CLK / 1000;
    localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int DEPTH = 1 << P_AVG_LOG2;
    localparam int SUM_W = 8 + P_AVG_LOG2;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);
    localparam logic [11:0]      MIN_C    = 12'(P_MIN_INTERVAL_MS);
    localparam logic [11:0]      MAX_C    = 12'(P_MAX_INTERVAL_MS);
    localparam logic [11:0]      TO_C     = 12'(P_TIMEOUT_MS);
    localparam logic [15:0]      DIVIDEND = 16'd60000;

    typedef enum logic [2:0] {
        WAIT_FIRST = 3'd0,
        MEASURE    = 3'd1,
        DIV        = 3'd2,
        AVG        = 3'd3,
        OUT        = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic beat;
    assign beat = bus.i_beat_pulse;

    // control strobes from the output decoder
    logic cap_en, step_en, avg_en, out_en, to_evt;

    // -------------------------------------------------------------------------
    // ms prescaler; a beat realigns it so intervals start on a clean ms grid
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             pre_cnt <= '0;
        else if (beat || tick)  pre_cnt <= '0;
        else                    pre_cnt <= pre_cnt + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Interval counter. ivl_cap already includes a tick landing in this cycle,
    // so a beat exactly N ms after the previous one captures N, and the
    // timeout check sees the count the moment it reaches the limit.
    // -------------------------------------------------------------------------
    logic [11:0] ivl_cnt, ivl_cap;
    logic        in_range, to_hit;

    assign ivl_cap  = (tick && (ivl_cnt < TO_C)) ? ivl_cnt + 12'd1 : ivl_cnt;
    assign in_range = (ivl_cap >= MIN_C) && (ivl_cap <= MAX_C);
    assign to_hit   = (ivl_cap >= TO_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ivl_cnt <= '0;
        else if (beat)  ivl_cnt <= '0;
        else            ivl_cnt <= ivl_cap;
    end

    // -------------------------------------------------------------------------
    // Restoring divider: dividend shifts out of dvd's MSB while quotient bits
    // shift in at the LSB; after 16 steps dvd holds the quotient.
    // rem < divisor always holds, so 12 bits of remainder are enough.
    // -------------------------------------------------------------------------
    logic [15:0] dvd;
    logic [11:0] rem, dsr, rem_sub;
    logic [12:0] rem_sh;
    logic [3:0]  div_cnt;
    logic        q_bit;

    assign rem_sh  = {rem, dvd[15]};
    assign q_bit   = (rem_sh >= {1'b0, dsr});
    assign rem_sub = rem_sh[11:0] - dsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd     <= '0;
            rem     <= '0;
            dsr     <= '0;
            div_cnt <= '0;
        end else if (cap_en) begin
            dvd     <= DIVIDEND;
            rem     <= '0;
            dsr     <= ivl_cap;
            div_cnt <= '0;
        end else if (step_en) begin
            dvd     <= {dvd[14:0], q_bit};
            rem     <= q_bit ? rem_sub : rem_sh[11:0];
            div_cnt <= div_cnt + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Moving average over a circular history; ptr always points at the oldest
    // slot. avg_cur is the average currently on o_heart_rate.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0][7:0]  hist;
    logic [P_AVG_LOG2-1:0]  ptr;
    logic [SUM_W-1:0]       sum;
    logic                   seeded;
    logic [7:0]             q, avg_cur;
    logic                   reject, reseed;

    assign q       = dvd[7:0];   // quotient is at most 219
    assign avg_cur = sum[SUM_W-1:P_AVG_LOG2];

`ifdef HR_OUTLIER_REJECT_EN
    logic [7:0] dev;
    logic       outlier;
    logic [1:0] rej_cnt;

    assign dev     = (q > avg_cur) ? q - avg_cur : avg_cur - q;
    assign outlier = seeded && (dev > {2'b00, avg_cur[7:2]});
    // third consecutive outlier is taken as a genuine rate change
    assign reject  = outlier && (rej_cnt != 2'd2);
    assign reseed  = !seeded || outlier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rej_cnt <= '0;
        else if (to_evt)         rej_cnt <= '0;
        else if (state == AVG)   rej_cnt <= reject ? rej_cnt + 2'd1 : 2'd0;
    end
`else
    assign reject = 1'b0;
    assign reseed = !seeded;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            ptr    <= '0;
            sum    <= '0;
            seeded <= 1'b0;
        end else if (to_evt) begin
            hist   <= '0;
            ptr    <= '0;
            sum    <= '0;
            seeded <= 1'b0;
        end else if (avg_en) begin
            seeded <= 1'b1;
            if (reseed) begin
                for (int i = 0; i < DEPTH; i++) hist[i] <= q;
                sum <= {q, {P_AVG_LOG2{1'b0}}};
                ptr <= '0;
            end else begin
                hist[ptr] <= q;
                sum       <= sum - {{P_AVG_LOG2{1'b0}}, hist[ptr]}
                                 + {{P_AVG_LOG2{1'b0}}, q};
                ptr       <= ptr + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FIRST;
        else        state <= state_nxt;
    end

    // FSM: next state. A beat in MEASURE always wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FIRST: if (beat) state_nxt = MEASURE;
            MEASURE: begin
                if (beat) begin
                    if (in_range) state_nxt = DIV;
                end else if (to_hit) begin
                    state_nxt = WAIT_FIRST;
                end
            end
            DIV:     if (div_cnt == 4'd15) state_nxt = AVG;
            AVG:     state_nxt = reject ? MEASURE : OUT;
            OUT:     state_nxt = MEASURE;
            default: state_nxt = WAIT_FIRST;
        endcase
    end

    // FSM: output decode. Beats outside MEASURE only restart the counters.
    always_comb begin
        cap_en  = 1'b0;
        step_en = 1'b0;
        avg_en  = 1'b0;
        out_en  = 1'b0;
        to_evt  = 1'b0;
        case (state)
            MEASURE: begin
                cap_en = beat && in_range;
                to_evt = !beat && to_hit;
            end
            DIV:     step_en = 1'b1;
            AVG:     avg_en  = !reject;
            OUT:     out_en  = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic [7:0] heart_rate;
    logic       hr_valid, result_valid, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heart_rate   <= '0;
            hr_valid     <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= out_en;
            timeout      <= to_evt;
            if (to_evt) begin
                heart_rate <= '0;
                hr_valid   <= 1'b0;
            end else if (out_en) begin
                heart_rate <= avg_cur;
                hr_valid   <= 1'b1;
            end
        end
    end

    assign bus.o_heart_rate   = heart_rate;
    assign bus.o_hr_valid     = hr_valid;
    assign bus.o_result_valid = result_valid;
    assign bus.o_timeout      = timeout;

endmodule

// File: tb/tb_hr_interval_calc.sv
// -----------------------------------------------------------------------------
// tb_hr_interval_calc
// Self-checking bench for hr_interval_calc. The ms prescaler is shortened to
// 2 clocks per ms so that multi-second beat gaps stay short. Beats are placed
// on exact clock edges so each gap of N ms yields a captured interval of N.
// Expected results come from a queue-based model of the heart-rate rules.
// -----------------------------------------------------------------------------
module tb_hr_interval_calc;

    localparam int PRE   = 2;
    localparam int MIN   = 273;
    localparam int MAX   = 2000;
    localparam int TO    = 3000;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hr_interval_calc_if bus ();

    hr_interval_calc #(
        .P_SYS_CLK         (PRE * 1000),
        .P_MIN_INTERVAL_MS (MIN),
        .P_MAX_INTERVAL_MS (MAX),
        .P_TIMEOUT_MS      (TO),
        .P_AVG_LOG2        (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // edge counter and output monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int res_cnt = 0, res_cyc = 0, res_hr = 0;
    int to_cnt = 0, to_cyc = 0;
    always @(negedge clk) begin
        if (bus.o_result_valid) begin
            res_cnt <= res_cnt + 1;
            res_cyc <= cyc;
            res_hr  <= int'(bus.o_heart_rate);
        end
        if (bus.o_timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
    end

    // ---------------- reference model ----------------
    int started = 0;
    int m_hr    = 0;
    int m_valid = 0;
    int rej     = 0;
    int hist[$];

    task automatic model_reset();
        started = 0; m_hr = 0; m_valid = 0; rej = 0;
        hist.delete();
    endtask

    // ms = time since the previous beat; returns expected result/timeout
    task automatic model_beat(input int ms, output int er, output int ehr, output int eto);
        int q, s, ok;
        er = 0; ehr = 0; eto = 0;
        if (started != 0 && ms > TO) begin
            eto = 1;
            model_reset();
        end
        if (started == 0) begin
            started = 1;
        end else if (ms >= MIN && ms <= MAX) begin
            q  = 60000 / ms;
            ok = 1;
            if (hist.size() == 0) begin
                repeat (DEPTH) hist.push_back(q);
            end else begin
`ifdef HR_OUTLIER_REJECT_EN
                if ((q > m_hr ? q - m_hr : m_hr - q) > m_hr / 4) begin
                    if (rej < 2) begin
                        rej++;
                        ok = 0;
                    end else begin
                        hist.delete();
                        repeat (DEPTH) hist.push_back(q);
                        ok = 2;
                    end
                end
`endif
                if (ok == 1) begin
                    void'(hist.pop_front());
                    hist.push_back(q);
                end
            end
            if (ok != 0) begin
                rej = 0;
                s = 0;
                foreach (hist[i]) s += hist[i];
                m_hr = s / DEPTH;
                m_valid = 1;
                er = 1;
                ehr = m_hr;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int last_edge = 0;

    task automatic wait_edge(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // beat sampled exactly ms*PRE edges after the previous beat's sample edge
    task automatic fire(input int ms);
        while (cyc < last_edge + ms * PRE - 1) wait_edge(1);
        bus.i_beat_pulse = 1'b1;
        wait_edge(1);
        bus.i_beat_pulse = 1'b0;
        last_edge = cyc;
    endtask

    // tp >= 0 adds a check against a hand-computed heart rate
    task automatic do_beat(input int ms, input int tp);
        int er, ehr, eto, r0, t0, prev;
        model_beat(ms, er, ehr, eto);
        r0 = res_cnt; t0 = to_cnt; prev = last_edge;
        fire(ms);
        wait_edge(22);
        chk("res_cnt", res_cnt - r0, er);
        if (er != 0) begin
            // result pulse registered 18 edges after the sampling edge,
            // i.e. high in the 19th cycle after the one presenting the beat
            chk("latency", res_cyc - last_edge, 18);
            chk("res_hr", res_hr, ehr);
        end
        chk("to_cnt", to_cnt - t0, eto);
        if (eto != 0) chk("to_time", to_cyc - prev, TO * PRE);
        chk("hr", int'(bus.o_heart_rate), m_hr);
        chk("hr_valid", int'(bus.o_hr_valid), m_valid);
        if (tp >= 0) chk("plan_hr", int'(bus.o_heart_rate), tp);
    endtask

    initial begin
        int r0;
        int used_to;
        bus.i_beat_pulse = 1'b0;
        used_to = 0;

        // async reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst_hr", int'(bus.o_heart_rate), 0);
        chk("rst_valid", int'(bus.o_hr_valid), 0);
        chk("rst_res", int'(bus.o_result_valid), 0);
        chk("rst_to", int'(bus.o_timeout), 0);
        wait_edge(3);
        rst_n = 1'b1;
        last_edge = cyc;
        model_reset();

        // lock at 75, then a 150 bpm step
        do_beat(10, 0);
        do_beat(800, 75);
`ifdef HR_OUTLIER_REJECT_EN
        do_beat(400, 75);
        do_beat(400, 75);
        do_beat(400, 150);
`else
        do_beat(400, 93);
        do_beat(400, 112);
        do_beat(400, 131);
`endif
        // loss of lock, then relock
        do_beat(3100, 0);
        do_beat(800, 75);
        do_beat(250, 75);
        do_beat(800, 75);
        do_beat(1000, 71);
        // range edges and beat coincident with the timeout tick
        do_beat(MIN, -1);
        do_beat(MAX, -1);
        do_beat(TO, -1);

        // reset in the middle of a division
        r0 = res_cnt;
        fire(800);
        wait_edge(6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hr", int'(bus.o_heart_rate), 0);
        chk("mid_rst_valid", int'(bus.o_hr_valid), 0);
        chk("mid_rst_res", int'(bus.o_result_valid), 0);
        chk("mid_rst_to", int'(bus.o_timeout), 0);
        wait_edge(2);
        rst_n = 1'b1;
        last_edge = cyc;
        model_reset();
        wait_edge(25);
        chk("abort_res", res_cnt - r0, 0);
        do_beat(100, 0);
        do_beat(800, 75);

        // randomized gaps, at most one timeout
        for (int n = 0; n < 8; n++) begin
            int k, ms;
            k = int'($urandom_range(0, 9));
            if (k == 0)                      ms = int'($urandom_range(200, 272));
            else if (k == 1)                 ms = int'($urandom_range(2001, 2300));
            else if (k == 2 && used_to == 0) begin
                ms = int'($urandom_range(3001, 3050));
                used_to = 1;
            end else                         ms = int'($urandom_range(273, 1500));
            do_beat(ms, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hr_interval_calc.md
Name: hr_interval_calc

Overview:
Heart-rate computation stage inside ppg_process_top. It consumes the single-cycle beat pulse from the PPG peak detector and measures the beat-to-beat interval in milliseconds. It converts that interval to BPM with a sequential divider and smooths the result with a moving average. Its output drives o_heart_rate, which feeds the OLED and the 7-segment display path.

Parameters:
P_SYS_CLK, 50_000_000, clk frequency in Hz; the ms prescaler divides by P_SYS_CLK/1000.
P_MIN_INTERVAL_MS, 273, shortest accepted interval in ms (about 220 bpm).
P_MAX_INTERVAL_MS, 2000, longest accepted interval in ms (30 bpm).
P_TIMEOUT_MS, 3000, no-beat time after which the output clears.
P_AVG_LOG2, 2, log2 of the moving-average depth (4 samples).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_beat_pulse  input  1  one-cycle pulse per detected heartbeat
o_heart_rate  output  8  averaged BPM; 0 = no lock
o_hr_valid  output  1  level; 1 while the heart rate is locked
o_result_valid  output  1  one-cycle pulse when o_heart_rate updates
o_timeout  output  1  one-cycle pulse when lock is lost

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: o_heart_rate=0, o_hr_valid=0, o_result_valid=0, o_timeout=0, history cleared, FSM=WAIT_FIRST.
- Reset asserted at any point, including mid-division, returns the block to exactly these values.
- ms tick: prescaler counts 0..P_SYS_CLK/1000-1 and emits a one-cycle tick on wrap. A beat clears the prescaler.
- Interval counter (12 bit) counts ticks. A beat clears it to 0; it saturates at P_TIMEOUT_MS.
- FSM states: WAIT_FIRST, MEASURE, DIV, AVG, OUT.
- WAIT_FIRST: a beat only starts the interval count; no result is produced. Go to MEASURE.
- MEASURE, on a beat: latch the interval, then check its range.
  - Interval < P_MIN_INTERVAL_MS or > P_MAX_INTERVAL_MS: discard, stay in MEASURE, outputs unchanged.
  - Interval in range: go to DIV.
- DIV: restoring divider computes 60000 (16 bit) / interval (12 bit). It runs 16 iterations, one per cycle. The quotient is truncated and always fits in 8 bits (range 30..219).
- AVG, first sample after WAIT_FIRST: all 2^P_AVG_LOG2 history slots are seeded with the quotient.
- AVG, later samples: the oldest slot is replaced. The sum is kept in a 10-bit accumulator; average = sum >> P_AVG_LOG2 (truncated).
- OUT: o_heart_rate = average, o_result_valid=1 for one cycle, o_hr_valid=1. Return to MEASURE.
- Latency: i_beat_pulse sampled high in cycle T gives o_result_valid high in cycle T+19 (1 capture + 16 DIV + 1 AVG + 1 OUT).
- Beat during DIV/AVG/OUT: the interval counter still restarts. That beat's own interval is dropped; the next interval is measured normally.
- Timeout: the interval counter reaching P_TIMEOUT_MS in MEASURE triggers all of the following:
  - o_timeout pulse.
  - o_heart_rate=0, o_hr_valid=0.
  - History cleared; go to WAIT_FIRST.
- In WAIT_FIRST the counter saturates with no further pulses.
- A beat and the timeout tick in the same cycle: the beat wins and no timeout occurs.

Optional Feature:
HR_OUTLIER_REJECT_EN
- Defined: in AVG, once history is seeded, a quotient q with |q - current average| > (average >> 2) is rejected. There is no result pulse and outputs are unchanged.
- A 2-bit consecutive-reject counter tracks rejections. On the 3rd consecutive reject the sample is accepted and reseeds all slots.
- Any accepted sample clears the counter.
- Not defined: every in-range quotient is accepted. The reject counter logic is absent.

Test Plan:
- Beats every 800 ms after reset -> first beat gives no output; second gives o_heart_rate=75, o_hr_valid=1, o_result_valid exactly 19 cycles after the beat.
- Locked at 75, then one 1000 ms interval (60 bpm) -> o_heart_rate=(75*3+60)/4=71.
- Locked at 75, then a beat 250 ms later -> interval rejected, o_heart_rate stays 75, no o_result_valid. The next 800 ms beat gives 75.
- Locked, then no beat for 3000 ms -> o_timeout pulse, o_heart_rate=0, o_hr_valid=0. The next beat produces no result.
- Averages of 75, then a 400 ms interval (150):
  - With HR_OUTLIER_REJECT_EN: rejected, output stays 75; three consecutive 150s reseed to 150.
  - Without HR_OUTLIER_REJECT_EN: output becomes (225+150)/4=93.
- rst_n asserted during DIV -> all outputs 0 immediately (async). After release, the first beat is treated as WAIT_FIRST.
